// File: rtl/rhythm_pkg.sv
// Shared types and chart-word helpers for the per-lane rhythm judge.
package rhythm_pkg;

  typedef enum logic [1:0] {
    NOTE_TAP       = 2'b00,
    NOTE_HOLD_HEAD = 2'b01,
    NOTE_HOLD_TAIL = 2'b10
  } note_type_t;

  typedef enum logic [1:0] {
    JUDGE_NONE    = 2'b00,
    JUDGE_PERFECT = 2'b01,
    JUDGE_GOOD    = 2'b10,
    JUDGE_MISS    = 2'b11
  } judge_t;

  typedef enum logic [1:0] {
    WIN_PERFECT,
    WIN_GOOD,
    WIN_EARLY,
    WIN_LATE
  } win_class_t;

  localparam int DEF_PERF_WIN = 3;
  localparam int DEF_GOOD_WIN = 6;
  localparam logic [9:0] COMBO_MAX = 10'd1023;

  // The reserved type code behaves exactly like a TAP.
  function automatic note_type_t note_type(input logic [15:0] word);
    case (word[15:14])
      2'b01:   return NOTE_HOLD_HEAD;
      2'b10:   return NOTE_HOLD_TAIL;
      default: return NOTE_TAP;
    endcase
  endfunction

  function automatic logic [13:0] note_time(input logic [15:0] word);
    return word[13:0];
  endfunction

  function automatic logic signed [14:0] frame_diff(input logic [13:0] song,
                                                    input logic [13:0] t);
    return $signed({1'b0, song}) - $signed({1'b0, t});
  endfunction

endpackage

// File: rtl/judge_window.sv
// Classifies a signed frame offset into PERFECT/GOOD/EARLY/LATE.
module judge_window
  import rhythm_pkg::*;
#(
  parameter int PERF_WIN = DEF_PERF_WIN,
  parameter int GOOD_WIN = DEF_GOOD_WIN
) (
  input  logic signed [14:0] diff,
  output win_class_t         win_class
);

  localparam logic [14:0] PERF_LIM = 15'(PERF_WIN);
  localparam logic [14:0] GOOD_LIM = 15'(GOOD_WIN);

  logic [14:0] mag;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    mag       = diff[14] ? (~diff + 15'sd1) : diff;
    win_class = WIN_LATE;
    if (mag <= PERF_LIM)      win_class = WIN_PERFECT;
    else if (mag <= GOOD_LIM) win_class = WIN_GOOD;
    else if (diff[14])        win_class = WIN_EARLY;
  end

endmodule

// File: rtl/lane_judge.sv
// One lane's chart pointer, hold tracking, hit judgment and combo counter.
module lane_judge
  import rhythm_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int PERF_WIN = DEF_PERF_WIN,
  parameter int GOOD_WIN = DEF_GOOD_WIN
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] chart_len,
  input  logic              frame_tick,
  input  logic [13:0]       song_time,
  input  logic              key_level,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       head_word,
  input  logic [15:0]       next_word,
  output logic              judge_valid,
  output logic [1:0]        judge_result,
  output logic              holding,
  output logic [9:0]        combo,
  output logic [9:0]        max_combo,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_HOLD, S_DONE} state_t;

  localparam logic [ADDR_W:0] ONE_X = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] TWO_X = (ADDR_W + 1)'(2);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_d, ptr_inc1, ptr_skip;
  logic [ADDR_W:0]   ptr_ext, len_ext, inc1_sum, skip_sum;
  logic              key_prev, press, hit, fire;
  logic signed [14:0] diff;
  win_class_t        win_class;
  judge_t            verdict, hit_verdict;
  logic [9:0]        combo_d, max_d;

  assign diff = frame_diff(song_time, note_time(head_word));

  // Head press and tail release both judge the word at rom_addr, so one window serves both.
  judge_window #(.PERF_WIN(PERF_WIN), .GOOD_WIN(GOOD_WIN)) u_window (
    .diff      (diff),
    .win_class (win_class)
  );

  assign press       = key_level & ~key_prev;
  assign hit         = (win_class == WIN_PERFECT) || (win_class == WIN_GOOD);
  assign hit_verdict = (win_class == WIN_PERFECT) ? JUDGE_PERFECT : JUDGE_GOOD;

  // Pointer advances saturate at chart_len; a missed head also skips its tail word.
  always_comb begin
    ptr_ext  = {1'b0, rom_addr};
    len_ext  = {1'b0, chart_len};
    inc1_sum = ptr_ext + ONE_X;
    skip_sum = ptr_ext + ((note_type(next_word) == NOTE_HOLD_TAIL) ? TWO_X : ONE_X);
    ptr_inc1 = (inc1_sum > len_ext) ? chart_len : inc1_sum[ADDR_W-1:0];
    ptr_skip = (skip_sum > len_ext) ? chart_len : skip_sum[ADDR_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = rom_addr;
    fire    = 1'b0;
    verdict = JUDGE_MISS;
    case (state_q)
      S_PLAY: begin
        if (rom_addr >= chart_len) begin
          state_d = S_DONE;
        end else if (frame_tick && (win_class == WIN_LATE)) begin
          fire  = 1'b1;
          ptr_d = (note_type(head_word) == NOTE_HOLD_HEAD) ? ptr_skip : ptr_inc1;
        end else if (press && hit) begin
          fire    = 1'b1;
          verdict = hit_verdict;
          ptr_d   = ptr_inc1;
          if (note_type(head_word) == NOTE_HOLD_HEAD) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!key_level) begin
          fire    = 1'b1;
          verdict = hit ? hit_verdict : JUDGE_MISS;
          ptr_d   = ptr_inc1;
          state_d = S_PLAY;
        end else if (!diff[14]) begin
          fire    = 1'b1;
          verdict = JUDGE_PERFECT;
          ptr_d   = ptr_inc1;
          state_d = S_PLAY;
        end
      end
      default: ;
    endcase
    if (start) begin
      state_d = S_PLAY;
      ptr_d   = '0;
      fire    = 1'b0;
    end
  end

  always_comb begin
    combo_d = combo;
    if (fire) combo_d = (verdict == JUDGE_MISS) ? 10'd0 :
                        (combo == COMBO_MAX)    ? combo : combo + 10'd1;
    if (start) combo_d = 10'd0;
    max_d = start ? 10'd0 : ((combo_d > max_combo) ? combo_d : max_combo);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= S_IDLE;
      rom_addr     <= '0;
      key_prev     <= 1'b0;
      judge_valid  <= 1'b0;
      judge_result <= 2'b00;
      combo        <= '0;
      max_combo    <= '0;
    end else begin
      state_q     <= state_d;
      rom_addr    <= ptr_d;
      key_prev    <= key_level;
      judge_valid <= fire;
      if (fire) judge_result <= verdict;
      combo       <= combo_d;
      max_combo   <= max_d;
    end
  end

  assign holding = (state_q == S_HOLD);
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_lane_judge.sv
// Directed and randomized checks of lane_judge against a frame-level model.
module tb_lane_judge;
  import rhythm_pkg::*;

  localparam int AW = 8;
  localparam int PW = 3;
  localparam int GW = 6;

  localparam int MD_IDLE = 0;
  localparam int MD_PLAY = 1;
  localparam int MD_HOLD = 2;
  localparam int MD_DONE = 3;

  logic          Clk        = 1'b0;
  logic          Reset_n    = 1'b0;
  logic          start      = 1'b0;
  logic          frame_tick = 1'b0;
  logic          key_level  = 1'b0;
  logic [AW-1:0] chart_len  = '0;
  logic [13:0]   song_time  = '0;
  logic [AW-1:0] rom_addr;
  logic [15:0]   head_word, next_word;
  logic          judge_valid, holding, done;
  logic [1:0]    judge_result;
  logic [9:0]    combo, max_combo;

  logic [15:0] chart [256];

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;
  int last_t;

  int m_mode = MD_IDLE;
  int m_ptr = 0, m_combo = 0, m_max = 0, m_jr = 0;
  bit m_jv = 1'b0, m_kprev = 1'b0;

  always #5 Clk = ~Clk;

  assign head_word = chart[rom_addr];
  assign next_word = chart[rom_addr + 8'd1];

  lane_judge #(.ADDR_W(AW), .PERF_WIN(PW), .GOOD_WIN(GW)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .start        (start),
    .chart_len    (chart_len),
    .frame_tick   (frame_tick),
    .song_time    (song_time),
    .key_level    (key_level),
    .rom_addr     (rom_addr),
    .head_word    (head_word),
    .next_word    (next_word),
    .judge_valid  (judge_valid),
    .judge_result (judge_result),
    .holding      (holding),
    .combo        (combo),
    .max_combo    (max_combo),
    .done         (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input logic [1:0] ty, input int t);
    return {ty, 14'(t)};
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // 1 PERFECT, 2 GOOD, 0 early, 3 late: straight from the window definitions.
  function automatic int grade(input int d);
    int ad;
    ad = (d < 0) ? -d : d;
    if (ad <= PW) return 1;
    if (ad <= GW) return 2;
    return (d < 0) ? 0 : 3;
  endfunction

  task automatic model_judge(input int r);
    m_jv = 1'b1;
    m_jr = r;
    if (r == 3) m_combo = 0;
    else if (m_combo < 1023) m_combo++;
    if (m_combo > m_max) m_max = m_combo;
  endtask

  task automatic model_step();
    int d, g, len;
    logic [15:0] w;
    bit pressed;
    pressed  = key_level && !m_kprev;
    m_kprev  = key_level;
    m_jv     = 1'b0;
    len      = int'(chart_len);
    if (start) begin
      m_mode = MD_PLAY; m_ptr = 0; m_combo = 0; m_max = 0;
    end else begin
      w = chart[m_ptr];
      d = int'(song_time) - int'(w[13:0]);
      g = grade(d);
      if (m_mode == MD_PLAY) begin
        if (m_ptr >= len) m_mode = MD_DONE;
        else if (frame_tick && g == 3) begin
          model_judge(3);
          m_ptr = (w[15:14] == 2'b01) ? imin(m_ptr + 2, len) : m_ptr + 1;
        end else if (pressed && (g == 1 || g == 2)) begin
          model_judge(g);
          if (w[15:14] == 2'b01) m_mode = MD_HOLD;
          m_ptr = m_ptr + 1;
        end
      end else if (m_mode == MD_HOLD) begin
        if (!key_level) begin
          model_judge((g == 1 || g == 2) ? g : 3);
          m_ptr = imin(m_ptr + 1, len); m_mode = MD_PLAY;
        end else if (d >= 0) begin
          model_judge(1);
          m_ptr = imin(m_ptr + 1, len); m_mode = MD_PLAY;
        end
      end
    end
  endtask

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_mode = MD_IDLE; m_ptr = 0; m_combo = 0; m_max = 0; m_jr = 0;
      m_jv = 1'b0; m_kprev = 1'b0;
    end else begin
      model_step();
    end
  end

  always @(negedge Clk) begin
    if (cmp_on) begin
      check("rom_addr", 32'(rom_addr), m_ptr);
      check("judge_valid", 32'(judge_valid), 32'(m_jv));
      if (m_jv) check("judge_result", 32'(judge_result), m_jr);
      check("holding", 32'(holding), 32'(m_mode == MD_HOLD));
      check("combo", 32'(combo), m_combo);
      check("max_combo", 32'(max_combo), m_max);
      check("done", 32'(done), 32'(m_mode == MD_DONE));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  // The tick cycle sees the old time; the new time appears in the following cycle.
  task automatic pulse_tick(input int nt);
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    song_time  = 14'(nt);
  endtask

  task automatic press_once();
    key_level = 1'b1;
    @(negedge Clk);
    key_level = 1'b0;
  endtask

  task automatic clear_chart();
    for (int i = 0; i < 256; i++) chart[i] = 16'h0000;
  endtask

  task automatic load_hold(input int len);
    clear_chart();
    chart[0]  = mk(2'b01, 200);
    chart[1]  = mk(2'b10, 260);
    chart_len = AW'(len);
    song_time = 14'd199;
  endtask

  task automatic build_random_chart();
    int t, n, hl;
    clear_chart();
    t = 20;
    n = 0;
    while (n < 14) begin
      if ($urandom_range(2) == 0 && n < 13) begin
        hl = 8 + int'($urandom_range(30));
        chart[n]     = mk(2'b01, t);
        chart[n + 1] = mk(2'b10, t + hl);
        t += hl + 12 + int'($urandom_range(9));
        n += 2;
      end else begin
        chart[n] = mk(($urandom_range(5) == 0) ? 2'b11 : 2'b00, t);
        t += 10 + int'($urandom_range(14));
        n++;
      end
    end
    chart_len = AW'(n - int'($urandom_range(2)));
    last_t    = t;
  endtask

  initial begin
    int p;
    clear_chart();
    idle(2);
    check("reset rom_addr", 32'(rom_addr), 0);
    check("reset judge_valid", 32'(judge_valid), 0);
    check("reset judge_result", 32'(judge_result), 0);
    check("reset holding", 32'(holding), 0);
    check("reset combo", 32'(combo), 0);
    check("reset max_combo", 32'(max_combo), 0);
    check("reset done", 32'(done), 0);
    Reset_n = 1'b1;
    cmp_on  = 1'b1;
    idle(1);

    // TAP at 100 pressed at 102.
    chart[0] = mk(2'b00, 100); chart_len = 8'd1; song_time = 14'd95;
    do_start();
    pulse_tick(102); idle(1);
    press_once();
    check("tap102 valid", 32'(judge_valid), 1);
    check("tap102 result", 32'(judge_result), 32'(JUDGE_PERFECT));
    check("tap102 rom_addr", 32'(rom_addr), 1);
    check("tap102 combo", 32'(combo), 1);
    idle(2);
    check("tap102 done", 32'(done), 1);

    // Early press ignored, GOOD at 105, LATE miss on the tick at 107.
    clear_chart();
    chart[0] = mk(2'b00, 100); chart[1] = mk(2'b00, 100);
    chart_len = 8'd2; song_time = 14'd93;
    do_start();
    press_once();
    check("early ignored valid", 32'(judge_valid), 0);
    check("early ignored rom_addr", 32'(rom_addr), 0);
    pulse_tick(105); idle(1);
    press_once();
    check("good105 result", 32'(judge_result), 32'(JUDGE_GOOD));
    check("good105 combo", 32'(combo), 1);
    pulse_tick(107); idle(1);
    pulse_tick(108);
    check("late107 valid", 32'(judge_valid), 1);
    check("late107 result", 32'(judge_result), 32'(JUDGE_MISS));
    check("late107 combo", 32'(combo), 0);
    check("late107 max", 32'(max_combo), 1);
    check("late107 rom_addr", 32'(rom_addr), 2);

    // Hold 200..260 held to the end.
    load_hold(2);
    do_start();
    pulse_tick(200); idle(1);
    key_level = 1'b1;
    @(negedge Clk);
    check("hold head result", 32'(judge_result), 32'(JUDGE_PERFECT));
    check("hold engaged", 32'(holding), 1);
    pulse_tick(230);
    pulse_tick(259);
    check("hold mid holding", 32'(holding), 1);
    pulse_tick(260);
    @(negedge Clk);
    check("hold tail valid", 32'(judge_valid), 1);
    check("hold tail result", 32'(judge_result), 32'(JUDGE_PERFECT));
    check("hold tail rom_addr", 32'(rom_addr), 2);
    check("hold tail combo", 32'(combo), 2);
    check("hold tail holding", 32'(holding), 0);
    key_level = 1'b0;
    idle(1);

    // Same hold released at 230.
    load_hold(2);
    do_start();
    pulse_tick(200); idle(1);
    key_level = 1'b1;
    @(negedge Clk);
    pulse_tick(230);
    key_level = 1'b0;
    @(negedge Clk);
    check("early release result", 32'(judge_result), 32'(JUDGE_MISS));
    check("early release combo", 32'(combo), 0);
    check("early release rom_addr", 32'(rom_addr), 2);

    // Same hold never pressed: one MISS, tail skipped.
    load_hold(2);
    do_start();
    pulse_tick(200); idle(1);
    pulse_tick(207); idle(1);
    pulse_tick(208);
    check("head miss result", 32'(judge_result), 32'(JUDGE_MISS));
    check("head miss rom_addr", 32'(rom_addr), 2);
    @(negedge Clk);
    check("head miss single", 32'(judge_valid), 0);

    // Missed head at chart_len-1 saturates the pointer.
    load_hold(1);
    do_start();
    pulse_tick(210); idle(1);
    pulse_tick(211);
    check("sat miss rom_addr", 32'(rom_addr), 1);
    idle(2);
    check("sat miss done", 32'(done), 1);

    // Three TAPs all hit.
    clear_chart();
    chart[0] = mk(2'b00, 300); chart[1] = mk(2'b00, 310); chart[2] = mk(2'b00, 320);
    chart_len = 8'd3; song_time = 14'd300;
    do_start();
    press_once();
    pulse_tick(310); idle(1); press_once();
    pulse_tick(320); idle(1); press_once();
    check("three taps combo", 32'(combo), 3);
    idle(2);
    check("three taps done", 32'(done), 1);
    check("three taps max", 32'(max_combo), 3);

    // start aborts a hold, then reset mid-hold.
    load_hold(2);
    song_time = 14'd200;
    do_start();
    key_level = 1'b1;
    @(negedge Clk);
    do_start();
    check("abort holding", 32'(holding), 0);
    check("abort valid", 32'(judge_valid), 0);
    check("abort rom_addr", 32'(rom_addr), 0);
    key_level = 1'b0;
    idle(1);
    key_level = 1'b1;
    @(negedge Clk);
    check("rehold holding", 32'(holding), 1);
    #2 Reset_n = 1'b0;
    #1;
    check("async rst rom_addr", 32'(rom_addr), 0);
    check("async rst holding", 32'(holding), 0);
    check("async rst combo", 32'(combo), 0);
    check("async rst max", 32'(max_combo), 0);
    check("async rst valid", 32'(judge_valid), 0);
    check("async rst done", 32'(done), 0);
    @(negedge Clk);
    Reset_n   = 1'b1;
    key_level = 1'b0;
    do_start();
    check("restart rom_addr", 32'(rom_addr), 0);
    press_once();
    check("restart plays", 32'(judge_valid), 1);
    idle(1);

    // Randomized songs: mashing and long-press key styles.
    for (int s = 0; s < 4; s++) begin
      build_random_chart();
      song_time = 14'd0;
      key_level = 1'b0;
      do_start();
      p = (s % 2 == 1) ? 40 : 5;
      for (int f = 1; f <= last_t + 10; f++) begin
        if ($urandom_range(p - 1) == 0) key_level = ~key_level;
        pulse_tick(f);
        repeat (1 + $urandom_range(2)) begin
          if ($urandom_range(p - 1) == 0) key_level = ~key_level;
          start = ($urandom_range(1999) == 0);
          @(negedge Clk);
          start = 1'b0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
